// File: rtl/ram_arbiter.sv
// Round-robin, burst-limited arbiter sharing the single-ported program/data RAM
// between the CPU controller (requester 0) and the loader/DMA path (requester 1).
module ram_arbiter #(
  parameter int AW        = 12,
  parameter int DW        = 16,
  parameter int MAX_BURST = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic [1:0]    owner
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST);

  // Encodings double as the owner code.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  state_t        state, state_next;
  logic          rr, rr_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [CW-1:0] cnt_inc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      rr    <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      rr    <= rr_next;
      cnt   <= cnt_next;
    end
  end

  // rr names the side favoured the next time both request from IDLE.
  always_comb begin
    state_next = state;
    rr_next    = rr;
    cnt_next   = cnt;
    cnt_inc    = cnt + CW'(1);
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (req0 && (!req1 || !rr)) begin
          state_next = OWN0;
          rr_next    = 1'b1;
        end else if (req1) begin
          state_next = OWN1;
          rr_next    = 1'b0;
        end
      end
      OWN0: begin
        if (!req0) begin
          state_next = req1 ? OWN1 : IDLE;
          cnt_next   = '0;
        end else if (cnt_inc == CNT_LAST) begin
          cnt_next = '0;
          if (req1) begin
            state_next = OWN1;
            rr_next    = 1'b1;
          end
        end else begin
          cnt_next = cnt_inc;
        end
      end
      OWN1: begin
        if (!req1) begin
          state_next = req0 ? OWN0 : IDLE;
          cnt_next   = '0;
        end else if (cnt_inc == CNT_LAST) begin
          cnt_next = '0;
          if (req0) begin
            state_next = OWN0;
            rr_next    = 1'b0;
          end
        end else begin
          cnt_next = cnt_inc;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign gnt0  = (state == OWN0) && req0;
  assign gnt1  = (state == OWN1) && req1;
  assign owner = state;

  // The RAM port is held at zero whenever nobody has a beat accepted.
  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    if (gnt0) begin
      ram_addr  = addr0;
      ram_we    = we0;
      ram_wdata = wdata0;
    end else if (gnt1) begin
      ram_addr  = addr1;
      ram_we    = we1;
      ram_wdata = wdata1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      rvalid0 <= gnt0 && !we0;
      rvalid1 <= gnt1 && !we1;
    end
  end

  assign rdata0 = ram_rdata;
  assign rdata1 = ram_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: a behavioural RAM, a read-data scoreboard
// and one task per scenario.
module tb_ram_arbiter;

  localparam int AW = 12;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic [1:0]    owner;

  logic          d1_gnt0, d1_gnt1, d1_rvalid0, d1_rvalid1;
  logic [DW-1:0] d1_rdata0, d1_rdata1;
  logic [AW-1:0] d1_ram_addr;
  logic          d1_ram_we;
  logic [DW-1:0] d1_ram_wdata;
  logic [1:0]    d1_owner;

  typedef struct {
    bit            port;
    logic [DW-1:0] data;
    int            due;
  } rd_exp_t;

  rd_exp_t       sb[$];
  rd_exp_t       mon_e;
  logic [DW-1:0] mem     [0:4095];
  logic [DW-1:0] exp_mem [0:4095];
  bit            mem_loaded = 1'b0;
  int            cyc = 0;
  int            checks_total = 0;
  int            checks_passed = 0;

  ram_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(8)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .owner(owner)
  );

  // Second instance with single-beat bursts; shares the stimulus, RAM port unused.
  ram_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(1)) dut1 (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(d1_gnt0), .gnt1(d1_gnt1), .rvalid0(d1_rvalid0), .rvalid1(d1_rvalid1),
    .rdata0(d1_rdata0), .rdata1(d1_rdata1),
    .ram_addr(d1_ram_addr), .ram_we(d1_ram_we), .ram_wdata(d1_ram_wdata),
    .ram_rdata(ram_rdata), .owner(d1_owner)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 4096; i++) mem[i] <= (i == 5) ? 16'hBEEF : 16'h0000;
      mem_loaded <= 1'b1;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  // Read-return monitor: every cycle either the due read arrives or rvalid stays low.
  always @(negedge clk) begin
    #2;
    if (sb.size() > 0 && sb[0].due <= cyc) begin
      mon_e = sb.pop_front();
      checks_total++;
      if (mon_e.due != cyc || (mon_e.port ? rvalid1 : rvalid0) !== 1'b1 ||
          (mon_e.port ? rdata1 : rdata0) !== mon_e.data)
        $display("[TB] FAIL rdata%0d @%0d: got valid=%b data=%h, want valid=1 data=%h due=%0d",
                 mon_e.port, cyc, mon_e.port ? rvalid1 : rvalid0,
                 mon_e.port ? rdata1 : rdata0, mon_e.data, mon_e.due);
      else checks_passed++;
    end else begin
      checks_total++;
      if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0)
        $display("[TB] FAIL spurious_rvalid @%0d: got %b%b, want 00", cyc, rvalid1, rvalid0);
      else checks_passed++;
    end
  end

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic drive0(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req0 = r; we0 = w; addr0 = a; wdata0 = d;
  endtask

  task automatic drive1(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req1 = r; we1 = w; addr1 = a; wdata1 = d;
  endtask

  task automatic push_read(input bit port, input logic [AW-1:0] a);
    sb.push_back('{port: port, data: exp_mem[a], due: cyc + 1});
  endtask

  task automatic test_reset();
    next_cycle();
    next_cycle();
    drive0(1'b1, 1'b1, 12'h005, 16'h1234);
    drive1(1'b1, 1'b1, 12'h100, 16'h5678);
    #1;
    checks_total++; if (owner !== 2'b00) $display("[TB] FAIL rst_owner: got %b want 00", owner); else checks_passed++;
    checks_total++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) $display("[TB] FAIL rst_gnt: got %b%b want 00", gnt1, gnt0); else checks_passed++;
    checks_total++; if (ram_addr !== 12'h000) $display("[TB] FAIL rst_ram_addr: got %h want 000", ram_addr); else checks_passed++;
    checks_total++; if (ram_we !== 1'b0) $display("[TB] FAIL rst_ram_we: got %b want 0", ram_we); else checks_passed++;
    checks_total++; if (ram_wdata !== 16'h0000) $display("[TB] FAIL rst_ram_wdata: got %h want 0000", ram_wdata); else checks_passed++;
    next_cycle();
    drive0(1'b0, 1'b0, 12'h000, 16'h0000);
    drive1(1'b0, 1'b0, 12'h000, 16'h0000);
    reset = 1'b1;
    #1;
    checks_total++; if (owner !== 2'b00 || d1_owner !== 2'b00) $display("[TB] FAIL rst_release_owner: got %b/%b want 00/00", owner, d1_owner); else checks_passed++;
  endtask

  task automatic test_single_read();
    next_cycle();
    drive0(1'b1, 1'b0, 12'h005, 16'h0000);
    #1;
    checks_total++; if (gnt0 !== 1'b0 || owner !== 2'b00) $display("[TB] FAIL rd_req_cycle: got gnt0=%b owner=%b want 0/00", gnt0, owner); else checks_passed++;
    next_cycle();
    #1;
    checks_total++; if (gnt0 !== 1'b1) $display("[TB] FAIL rd_gnt0: got %b want 1", gnt0); else checks_passed++;
    checks_total++; if (owner !== 2'b01) $display("[TB] FAIL rd_owner: got %b want 01", owner); else checks_passed++;
    checks_total++; if (ram_addr !== 12'h005 || ram_we !== 1'b0) $display("[TB] FAIL rd_ram_port: got addr=%h we=%b want 005/0", ram_addr, ram_we); else checks_passed++;
    push_read(1'b0, 12'h005);
    next_cycle();
    drive0(1'b0, 1'b0, 12'h000, 16'h0000);
    #1;
    checks_total++; if (gnt0 !== 1'b0 || ram_addr !== 12'h000) $display("[TB] FAIL rd_release: got gnt0=%b addr=%h want 0/000", gnt0, ram_addr); else checks_passed++;
    next_cycle();
    #1;
    checks_total++; if (owner !== 2'b00) $display("[TB] FAIL rd_idle_owner: got %b want 00", owner); else checks_passed++;
  endtask

  task automatic test_write_burst();
    next_cycle();
    drive1(1'b1, 1'b1, 12'h100, 16'h1111);
    #1;
    checks_total++; if (gnt1 !== 1'b0 || ram_we !== 1'b0) $display("[TB] FAIL wr_req_cycle: got gnt1=%b we=%b want 0/0", gnt1, ram_we); else checks_passed++;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      drive1(1'b1, 1'b1, AW'(12'h100 + i), DW'(16'h1111 * (i + 1)));
      #1;
      checks_total++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0) $display("[TB] FAIL wr_gnt beat %0d: got %b%b want 10", i, gnt1, gnt0); else checks_passed++;
      checks_total++; if (ram_we !== 1'b1 || ram_addr !== AW'(12'h100 + i) || ram_wdata !== DW'(16'h1111 * (i + 1)))
        $display("[TB] FAIL wr_ram_port beat %0d: got we=%b addr=%h data=%h want 1/%h/%h", i, ram_we, ram_addr, ram_wdata, AW'(12'h100 + i), DW'(16'h1111 * (i + 1)));
      else checks_passed++;
      exp_mem[12'h100 + i] = DW'(16'h1111 * (i + 1));
    end
    next_cycle();
    drive1(1'b0, 1'b0, 12'h000, 16'h0000);
    #1;
    checks_total++; if (gnt1 !== 1'b0 || ram_we !== 1'b0) $display("[TB] FAIL wr_end: got gnt1=%b we=%b want 0/0", gnt1, ram_we); else checks_passed++;
    next_cycle();
    drive1(1'b1, 1'b0, 12'h100, 16'h0000);
    #1;
    checks_total++; if (gnt1 !== 1'b0) $display("[TB] FAIL rb_req_cycle: got gnt1=%b want 0", gnt1); else checks_passed++;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      drive1(1'b1, 1'b0, AW'(12'h100 + i), 16'h0000);
      #1;
      checks_total++; if (gnt1 !== 1'b1 || ram_we !== 1'b0) $display("[TB] FAIL rb_gnt beat %0d: got gnt1=%b we=%b want 1/0", i, gnt1, ram_we); else checks_passed++;
      push_read(1'b1, AW'(12'h100 + i));
    end
    next_cycle();
    drive1(1'b0, 1'b0, 12'h000, 16'h0000);
    next_cycle();
  endtask

  task automatic test_contention();
    logic exp0, exp1;
    next_cycle();
    reset = 1'b0;
    drive0(1'b1, 1'b0, 12'h100, 16'h0000);
    drive1(1'b1, 1'b0, 12'h005, 16'h0000);
    next_cycle();
    reset = 1'b1;
    #1;
    checks_total++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) $display("[TB] FAIL ct_idle: got %b%b want 00", gnt1, gnt0); else checks_passed++;
    for (int k = 1; k <= 17; k++) begin
      next_cycle();
      drive0(1'b1, 1'b0, AW'(12'h100 + (k % 4)), 16'h0000);
      #1;
      exp0 = (k <= 8) || (k == 17);
      exp1 = (k > 8) && (k <= 16);
      checks_total++; if (gnt0 !== exp0 || gnt1 !== exp1) $display("[TB] FAIL ct_gnt k=%0d: got %b%b want %b%b", k, gnt1, gnt0, exp1, exp0); else checks_passed++;
      checks_total++; if (owner !== (exp0 ? 2'b01 : 2'b10)) $display("[TB] FAIL ct_owner k=%0d: got %b want %b", k, owner, exp0 ? 2'b01 : 2'b10); else checks_passed++;
      checks_total++; if (ram_addr !== (exp0 ? AW'(12'h100 + (k % 4)) : 12'h005)) $display("[TB] FAIL ct_addr k=%0d: got %h", k, ram_addr); else checks_passed++;
      checks_total++; if (d1_gnt0 !== 1'((k % 2) == 1) || d1_gnt1 !== 1'((k % 2) == 0))
        $display("[TB] FAIL ct_b1_gnt k=%0d: got %b%b want %b%b", k, d1_gnt1, d1_gnt0, 1'((k % 2) == 0), 1'((k % 2) == 1));
      else checks_passed++;
      if (exp0) push_read(1'b0, AW'(12'h100 + (k % 4)));
      if (exp1) push_read(1'b1, 12'h005);
    end
    next_cycle();
    drive0(1'b0, 1'b0, 12'h000, 16'h0000);
    drive1(1'b0, 1'b0, 12'h000, 16'h0000);
    #1;
    checks_total++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) $display("[TB] FAIL ct_end: got %b%b want 00", gnt1, gnt0); else checks_passed++;
    next_cycle();
  endtask

  task automatic test_voluntary_release();
    next_cycle();
    drive0(1'b1, 1'b0, 12'h005, 16'h0000);
    #1;
    checks_total++; if (gnt0 !== 1'b0) $display("[TB] FAIL vr_req_cycle: got gnt0=%b want 0", gnt0); else checks_passed++;
    for (int k = 1; k <= 3; k++) begin
      next_cycle();
      drive1(1'b1, 1'b1, 12'h200, 16'hA000);
      #1;
      checks_total++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) $display("[TB] FAIL vr_own0 k=%0d: got %b%b want 01", k, gnt1, gnt0); else checks_passed++;
      push_read(1'b0, 12'h005);
    end
    next_cycle();
    drive0(1'b0, 1'b0, 12'h000, 16'h0000);
    #1;
    checks_total++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || ram_we !== 1'b0) $display("[TB] FAIL vr_gap: got gnt=%b%b we=%b want 00/0", gnt1, gnt0, ram_we); else checks_passed++;
    checks_total++; if (owner !== 2'b01) $display("[TB] FAIL vr_gap_owner: got %b want 01", owner); else checks_passed++;
    for (int j = 0; j < 3; j++) begin
      next_cycle();
      drive1(1'b1, 1'b1, AW'(12'h200 + j), DW'(16'hA000 + j));
      #1;
      checks_total++; if (owner !== 2'b10 || gnt1 !== 1'b1) $display("[TB] FAIL vr_own1 j=%0d: got owner=%b gnt1=%b want 10/1", j, owner, gnt1); else checks_passed++;
      checks_total++; if (ram_we !== 1'b1 || ram_wdata !== DW'(16'hA000 + j)) $display("[TB] FAIL vr_wr j=%0d: got we=%b data=%h want 1/%h", j, ram_we, ram_wdata, DW'(16'hA000 + j)); else checks_passed++;
      exp_mem[12'h200 + j] = DW'(16'hA000 + j);
    end
    next_cycle();
    drive1(1'b0, 1'b0, 12'h000, 16'h0000);
    #1;
    checks_total++; if (gnt1 !== 1'b0) $display("[TB] FAIL vr_end: got gnt1=%b want 0", gnt1); else checks_passed++;
    next_cycle();
  endtask

  task automatic test_lone_requester();
    next_cycle();
    drive0(1'b1, 1'b0, 12'h200, 16'h0000);
    #1;
    checks_total++; if (gnt0 !== 1'b0) $display("[TB] FAIL lone_req_cycle: got gnt0=%b want 0", gnt0); else checks_passed++;
    for (int k = 0; k < 20; k++) begin
      next_cycle();
      drive0(1'b1, 1'b0, AW'(12'h200 + (k % 3)), 16'h0000);
      #1;
      checks_total++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || owner !== 2'b01)
        $display("[TB] FAIL lone_beat k=%0d: got gnt=%b%b owner=%b want 01/01", k, gnt1, gnt0, owner);
      else checks_passed++;
      push_read(1'b0, AW'(12'h200 + (k % 3)));
    end
    next_cycle();
    drive0(1'b0, 1'b0, 12'h000, 16'h0000);
    #1;
    checks_total++; if (gnt0 !== 1'b0) $display("[TB] FAIL lone_end: got gnt0=%b want 0", gnt0); else checks_passed++;
    next_cycle();
  endtask

  task automatic test_reset_mid_read();
    next_cycle();
    drive0(1'b1, 1'b0, 12'h005, 16'h0000);
    #1;
    checks_total++; if (gnt0 !== 1'b0) $display("[TB] FAIL rmr_req_cycle: got gnt0=%b want 0", gnt0); else checks_passed++;
    next_cycle();
    #1;
    checks_total++; if (gnt0 !== 1'b1) $display("[TB] FAIL rmr_gnt: got gnt0=%b want 1", gnt0); else checks_passed++;
    reset = 1'b0;
    #1;
    checks_total++; if (owner !== 2'b00 || gnt0 !== 1'b0) $display("[TB] FAIL rmr_async: got owner=%b gnt0=%b want 00/0", owner, gnt0); else checks_passed++;
    checks_total++; if (ram_addr !== 12'h000 || ram_we !== 1'b0 || ram_wdata !== 16'h0000)
      $display("[TB] FAIL rmr_ram_port: got addr=%h we=%b data=%h want 000/0/0000", ram_addr, ram_we, ram_wdata);
    else checks_passed++;
    drive0(1'b0, 1'b0, 12'h000, 16'h0000);
    next_cycle();
    #1;
    checks_total++; if (rvalid0 !== 1'b0) $display("[TB] FAIL rmr_rvalid_dropped: got %b want 0", rvalid0); else checks_passed++;
    reset = 1'b1;
    drive0(1'b1, 1'b0, 12'h005, 16'h0000);
    #1;
    checks_total++; if (gnt0 !== 1'b0 || owner !== 2'b00) $display("[TB] FAIL rmr_release: got gnt0=%b owner=%b want 0/00", gnt0, owner); else checks_passed++;
    next_cycle();
    #1;
    checks_total++; if (gnt0 !== 1'b1) $display("[TB] FAIL rmr_regrant: got gnt0=%b want 1", gnt0); else checks_passed++;
    push_read(1'b0, 12'h005);
    next_cycle();
    drive0(1'b0, 1'b0, 12'h000, 16'h0000);
    next_cycle();
  endtask

  initial begin
    reset = 1'b0;
    drive0(1'b0, 1'b0, 12'h000, 16'h0000);
    drive1(1'b0, 1'b0, 12'h000, 16'h0000);
    for (int i = 0; i < 4096; i++) exp_mem[i] = 16'h0000;
    exp_mem[5] = 16'hBEEF;
    test_reset();
    test_single_read();
    test_write_burst();
    test_contention();
    test_voluntary_release();
    test_lone_requester();
    test_reset_mid_read();
    next_cycle();
    #3;
    checks_total++;
    if (sb.size() != 0) $display("[TB] FAIL scoreboard_drain: got %0d pending reads want 0", sb.size());
    else checks_passed++;
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish by 200000 want finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter that shares the single-ported program/data RAM between the CPU controller (requester 0) and the program loader/DMA path (requester 1). It sits between the requesters and the `ram` block and drives the RAM address, write-enable and write-data lines. Ownership is granted in bursts under a round-robin policy with a bounded burst length, so neither side can starve the other. Read data is returned one cycle after each accepted read beat.

## Interface
- `AW`, 12, address width (matches the MAR width)
- `DW`, 16, data width (matches the bus width)
- `MAX_BURST`, 8, maximum beats per ownership period while the other side is waiting; must be ≥1
- `clk` input 1: system clock, rising edge
- `reset` input 1: asynchronous, active-low reset
- `req0`, `req1` input 1 each: requester wants the RAM; hold high for the whole burst
- `we0`, `we1` input 1 each: beat is a write (1) or a read (0)
- `addr0`, `addr1` input AW each: beat address
- `wdata0`, `wdata1` input DW each: write data
- `gnt0`, `gnt1` output 1 each: beat accepted this cycle
- `rvalid0`, `rvalid1` output 1 each: read data valid; pulses one cycle after an accepted read
- `rdata0`, `rdata1` output DW each: read data; both equal `ram_rdata`
- `ram_addr` output AW, `ram_we` output 1, `ram_wdata` output DW: RAM port
- `ram_rdata` input DW: RAM synchronous read data, one-cycle latency
- `owner` output 2: 00 = IDLE, 01 = requester 0, 10 = requester 1

## Operation
- States: IDLE, OWN0, OWN1.
- Registers: state; round-robin pointer `rr` (the favoured requester); beat counter `cnt` of width clog2(MAX_BURST+1); a registered `rvalid` per requester.
- `gnt_i = (state == OWN_i) && req_i`, combinational. A beat is accepted when `gnt_i` is 1.
- RAM port:
  - When `gnt_i` is high, `ram_addr`/`ram_wdata` are the owner's `addr_i`/`wdata_i`, and `ram_we = we_i`.
  - With no grant, all RAM outputs are 0. `ram_we` is never high without a grant.
- `rvalid_i` is registered: it is high in the cycle after an accepted beat with `we_i = 0`.
- IDLE:
  - If only one requester is active, go to that requester's OWN state.
  - If both are active, go to OWN[`rr`].
  - If neither is active, stay in IDLE.
- OWN_i, in priority order:
  - `req_i` is 0: no beat this cycle. Go to OWN_other if the other side is requesting, otherwise go to IDLE. Set `cnt` to 0.
  - An accepted beat brings `cnt` to MAX_BURST and the other side is requesting: go to OWN_other, set `cnt` to 0, set `rr` to the other side.
  - An accepted beat brings `cnt` to MAX_BURST and the other side is idle: stay in OWN_i and set `cnt` to 0.
  - Otherwise, increment `cnt` on each accepted beat.
- `rr` also updates on every entry from IDLE: it is set to point at the side that was not granted.
- Ownership moves directly from one owner to the other with no IDLE bubble. The next owner's first beat can be accepted in the cycle after the switch.

## Timing
- Reset values (asserted asynchronously while `reset` = 0):
  - state = IDLE, `owner` = 00, `rr` = 0, `cnt` = 0.
  - `gnt0`/`gnt1` = 0, `rvalid0`/`rvalid1` = 0.
  - `ram_addr`, `ram_we`, `ram_wdata` = 0.
- Arbitration latency: a request raised in IDLE at cycle t gets its grant at t+1. The first read returns `rvalid` at t+2.
- Reset mid-burst: the next edge after reset release starts from IDLE. A pending `rvalid` is dropped. The requester must reissue the beat.
- `addr`/`we`/`wdata` may change every cycle. Only their values in grant cycles matter.
- Both requests rising in the same cycle from reset: requester 0 wins (`rr` = 0).
- MAX_BURST = 1 with both sides requesting: grants alternate beat by beat.

## Test plan
- Single read from CPU: `req0` rises at cycle 2 with `addr0 = 0x005` and RAM[5] = 0xBEEF. Expect `gnt0` at cycle 3, `rvalid0` = 1 with `rdata0` = 0xBEEF at cycle 4, and `owner` = 01 from cycle 3.
- Loader write burst: `req1` with `we1 = 1` writes 0x100..0x103 ← 0x1111..0x4444. Expect 4 consecutive `gnt1` pulses, `ram_we` high only in those cycles, and RAM read back correct.
- Contention (MAX_BURST = 8): both requests held from reset. Expect 8 `gnt0` beats, then 8 `gnt1` beats, alternating, with no idle cycle between owners.
- Voluntary release: owner 0 drops `req0` after 3 beats while `req1` is high. Expect one cycle with no grant, then `owner` = 10 and the `gnt1` beats.
- Lone requester past the limit: `req0` held for 20 beats with `req1` = 0. Expect 20 uninterrupted `gnt0` beats and `owner` stays 01.
- Reset mid-read: `reset` pulled low in the cycle of an accepted read. Expect `rvalid0` = 0, `owner` = 00 and all RAM outputs 0 immediately. After release, a re-raised `req0` is granted one cycle later.
